// File: rtl/nrzi_decoder.sv
// NRZI receive decoder: line symbols -> unstuffed data bits, EOP detection, line error flags.
// Latency: one cycle; every output is registered, reflecting the symbol sampled at the previous edge.
// Backpressure: none; one symbol per clk at line rate, and bits are offered once on bit_valid.
//
// Ports:
//   clk        one line symbol sampled per rising edge
//   rst_L      asynchronous active-low reset; abandons any packet in flight silently
//   line_in    J=2'b10, K=2'b01, SE0=2'b00, SE1=2'b11 (illegal)
//   bit_out    decoded, unstuffed data bit, qualified by bit_valid
//   bit_valid  bit_out carries a data bit this cycle
//   rx_active  high from packet start until a clean EOP or error recovery completes
//   rx_done    one-cycle pulse on a clean EOP
//   rx_error   one-cycle pulse when a line error is detected
//   err_code   0 none, 1 stuff error, 2 bad EOP, 3 SE1; held until the next packet start
module nrzi_decoder #(
    parameter int STUFF_LEN = 6,
    parameter int MAX_SE0   = 3
) (
    input  logic       clk,
    input  logic       rst_L,
    input  logic [1:0] line_in,
    output logic       bit_out,
    output logic       bit_valid,
    output logic       rx_active,
    output logic       rx_done,
    output logic       rx_error,
    output logic [1:0] err_code
);

    localparam int OW = $clog2(STUFF_LEN + 1);
    localparam int SW = $clog2(MAX_SE0 + 1);

    localparam logic [1:0] SYM_J   = 2'b10;
    localparam logic [1:0] SYM_K   = 2'b01;
    localparam logic [1:0] SYM_SE0 = 2'b00;
    localparam logic [1:0] SYM_SE1 = 2'b11;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_STUFF = 2'd1;
    localparam logic [1:0] ERR_EOP   = 2'd2;
    localparam logic [1:0] ERR_SE1   = 2'd3;

    // S_ERR_SE0 remembers that an SE0 has been seen while recovering, so the
    // following J ends recovery.
    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_EOP,
        S_ERR,
        S_ERR_SE0
    } state_t;

    state_t          state, state_nxt;
    logic [1:0]      prev_sym, prev_sym_nxt;
    logic [OW-1:0]   ones_cnt, ones_cnt_nxt;
    logic [SW-1:0]   se0_cnt, se0_cnt_nxt;

    logic            bit_nxt, valid_nxt, active_nxt, done_nxt, error_nxt;
    logic [1:0]      code_nxt;

    logic            is_j, is_k, is_se0, is_se1, is_jk;
    logic            dbit, stuff_full, se0_at_max, se0_enough;

    assign is_j       = (line_in == SYM_J);
    assign is_k       = (line_in == SYM_K);
    assign is_se0     = (line_in == SYM_SE0);
    assign is_se1     = (line_in == SYM_SE1);
    assign is_jk      = is_j | is_k;
    // No level change decodes to 1, a J/K transition decodes to 0.
    assign dbit       = (line_in == prev_sym);
    assign stuff_full = (int'(ones_cnt) == STUFF_LEN);
    assign se0_at_max = (int'(se0_cnt) >= MAX_SE0);
    assign se0_enough = (int'(se0_cnt) >= 2);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (is_k) state_nxt = S_RECV;
            end
            S_RECV: begin
                // The data bit is judged before any SE0, so a stuff violation
                // on the last bit wins over the EOP that follows it.
                if (is_jk) begin
                    if (stuff_full && dbit) state_nxt = S_ERR;
                end else if (is_se0) begin
                    state_nxt = S_EOP;
                end else begin
                    state_nxt = S_ERR;
                end
            end
            S_EOP: begin
                if (is_se0) begin
                    if (se0_at_max) state_nxt = S_ERR;
                end else if (is_j && se0_enough) begin
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_ERR;
                end
            end
            S_ERR: begin
                if (is_se0) state_nxt = S_ERR_SE0;
            end
            S_ERR_SE0: begin
                if (is_j)        state_nxt = S_IDLE;
                else if (!is_se0) state_nxt = S_ERR;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- output / datapath logic ----------------
    always_comb begin
        bit_nxt      = 1'b0;
        valid_nxt    = 1'b0;
        done_nxt     = 1'b0;
        error_nxt    = 1'b0;
        code_nxt     = err_code;
        active_nxt   = rx_active;
        prev_sym_nxt = is_jk ? line_in : prev_sym;
        ones_cnt_nxt = ones_cnt;
        se0_cnt_nxt  = se0_cnt;

        unique case (state)
            S_IDLE: begin
                active_nxt = 1'b0;
                if (is_k) begin
                    // Idle line is J, so the first K is always a decoded 0.
                    bit_nxt      = 1'b0;
                    valid_nxt    = 1'b1;
                    ones_cnt_nxt = '0;
                    code_nxt     = ERR_NONE;
                    active_nxt   = 1'b1;
                end
            end
            S_RECV: begin
                if (is_jk) begin
                    if (stuff_full) begin
                        if (dbit) begin
                            error_nxt = 1'b1;
                            code_nxt  = ERR_STUFF;
                        end else begin
                            ones_cnt_nxt = '0;   // stuffed 0 is dropped
                        end
                    end else begin
                        bit_nxt      = dbit;
                        valid_nxt    = 1'b1;
                        ones_cnt_nxt = dbit ? ones_cnt + OW'(1) : '0;
                    end
                end else if (is_se0) begin
                    // A pending stuff bit at this point is legal; the count is
                    // simply abandoned.
                    se0_cnt_nxt = SW'(1);
                end else begin
                    error_nxt = 1'b1;
                    code_nxt  = ERR_SE1;
                end
            end
            S_EOP: begin
                if (is_se0) begin
                    if (se0_at_max) begin
                        error_nxt = 1'b1;
                        code_nxt  = ERR_EOP;
                    end else begin
                        se0_cnt_nxt = se0_cnt + SW'(1);
                    end
                end else if (is_j && se0_enough) begin
                    done_nxt   = 1'b1;
                    active_nxt = 1'b0;
                end else begin
                    error_nxt = 1'b1;
                    code_nxt  = is_se1 ? ERR_SE1 : ERR_EOP;
                end
            end
            S_ERR: begin
                // Recovery: hold rx_active, emit nothing until SE0 then J.
            end
            S_ERR_SE0: begin
                if (is_j) active_nxt = 1'b0;
            end
            default: begin
                active_nxt = 1'b0;
            end
        endcase
    end

    // ---------------- registered outputs and datapath ----------------
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            prev_sym  <= SYM_J;
            ones_cnt  <= '0;
            se0_cnt   <= '0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            rx_active <= 1'b0;
            rx_done   <= 1'b0;
            rx_error  <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            prev_sym  <= prev_sym_nxt;
            ones_cnt  <= ones_cnt_nxt;
            se0_cnt   <= se0_cnt_nxt;
            bit_out   <= bit_nxt;
            bit_valid <= valid_nxt;
            rx_active <= active_nxt;
            rx_done   <= done_nxt;
            rx_error  <= error_nxt;
            err_code  <= code_nxt;
        end
    end

endmodule

// File: tb/tb_nrzi_decoder.sv
// Bench for nrzi_decoder: packets are built from data bits by an NRZI/stuffing
// encoder model, which also records the decoder response expected per symbol.
module tb_nrzi_decoder;

    localparam logic [1:0] J   = 2'b10;
    localparam logic [1:0] K   = 2'b01;
    localparam logic [1:0] SE0 = 2'b00;
    localparam logic [1:0] SE1 = 2'b11;
    localparam int         STUFF = 6;

    logic       clk;
    logic       rst_L;
    logic [1:0] line_in;
    logic       bit_out, bit_valid, rx_active, rx_done, rx_error;
    logic [1:0] err_code;

    nrzi_decoder #(.STUFF_LEN(6), .MAX_SE0(3)) dut (
        .clk       (clk),
        .rst_L     (rst_L),
        .line_in   (line_in),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .rx_active (rx_active),
        .rx_done   (rx_done),
        .rx_error  (rx_error),
        .err_code  (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One applied symbol and the response expected one cycle later.
    typedef struct {
        logic [1:0] s;
        bit         v;
        bit         b;
        bit         d;
        bit         e;
        bit         a;
        logic [1:0] c;
    } step_t;

    step_t      q[$];
    logic [1:0] level;   // current line level of the encoder model
    int         ones;    // consecutive data 1s since last 0 / stuff
    logic [1:0] code;    // err_code the decoder should be holding
    int         vectors;
    int         errs;

    task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] flip(input logic [1:0] l);
        return (l == J) ? K : J;
    endfunction

    task automatic push(input logic [1:0] s, input bit v, input bit b,
                        input bit d, input bit e, input bit a);
        step_t st;
        st.s = s; st.v = v; st.b = b; st.d = d; st.e = e; st.a = a; st.c = code;
        q.push_back(st);
    endtask

    // Stuff lazily: a stuffed 0 is only inserted when another data bit follows,
    // so packets ending in six 1s reach EOP with a stuff bit pending.
    task automatic send_bit(input bit b);
        if (ones == STUFF) begin
            level = flip(level);
            push(level, 0, 0, 0, 0, 1);
            ones = 0;
        end
        if (!b) level = flip(level);
        push(level, 1, b, 0, 0, 1);
        ones = b ? ones + 1 : 0;
    endtask

    task automatic start_pkt(input int n);
        code = 2'd0;
        ones = 0;
        level = J;
        send_bit(1'b0);
        for (int i = 1; i < n; i++) send_bit($urandom_range(0, 3) != 0);
    endtask

    task automatic eop(input int nse0);
        for (int i = 0; i < nse0; i++) push(SE0, 0, 0, 0, 0, 1);
        push(J, 0, 0, 1, 0, 0);
        level = J;
        ones = 0;
    endtask

    task automatic raise(input logic [1:0] c, input logic [1:0] s);
        code = c;
        push(s, 0, 0, 0, 1, 1);
    endtask

    task automatic recover();
        int n;
        n = $urandom_range(0, 3);
        for (int i = 0; i < n; i++) push(($urandom_range(0, 1) != 0) ? J : K, 0, 0, 0, 0, 1);
        push(SE0, 0, 0, 0, 0, 1);
        push(J, 0, 0, 0, 0, 0);
        level = J;
        ones = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) push(J, 0, 0, 0, 0, 0);
    endtask

    task automatic run();
        step_t st;
        while (q.size() > 0) begin
            st = q.pop_front();
            @(negedge clk);
            line_in = st.s;
            @(posedge clk);
            #1;
            check_eq("bit_valid", {3'b0, bit_valid}, {3'b0, st.v});
            if (st.v) check_eq("bit_out", {3'b0, bit_out}, {3'b0, st.b});
            check_eq("rx_done", {3'b0, rx_done}, {3'b0, st.d});
            check_eq("rx_error", {3'b0, rx_error}, {3'b0, st.e});
            check_eq("rx_active", {3'b0, rx_active}, {3'b0, st.a});
            check_eq("err_code", {2'b0, err_code}, {2'b0, st.c});
        end
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_bit_out"},   {3'b0, bit_out},   4'd0);
        check_eq({tag, "_bit_valid"}, {3'b0, bit_valid}, 4'd0);
        check_eq({tag, "_rx_active"}, {3'b0, rx_active}, 4'd0);
        check_eq({tag, "_rx_done"},   {3'b0, rx_done},   4'd0);
        check_eq({tag, "_rx_error"},  {3'b0, rx_error},  4'd0);
        check_eq({tag, "_err_code"},  {2'b0, err_code},  4'd0);
    endtask

    // Asynchronous reset applied between clock edges; outputs must clear at once.
    task automatic do_reset(input string tag);
        #2 rst_L = 1'b0;
        #1 check_zero(tag);
        @(negedge clk);
        line_in = J;
        rst_L = 1'b1;
        level = J;
        ones = 0;
        code = 2'd0;
    endtask

    task automatic scenario(input int k);
        case (k)
            0, 1, 2: begin
                start_pkt($urandom_range(1, 24));
                eop($urandom_range(2, 3));
            end
            3: begin
                start_pkt($urandom_range(1, 12));
                while (ones < STUFF) send_bit(1'b1);
                raise(2'd1, level);
                recover();
            end
            4: begin
                start_pkt($urandom_range(1, 12));
                push(SE0, 0, 0, 0, 0, 1);
                raise(2'd2, J);
                recover();
            end
            5: begin
                start_pkt($urandom_range(1, 12));
                for (int i = 0; i < 3; i++) push(SE0, 0, 0, 0, 0, 1);
                raise(2'd2, SE0);
                recover();
            end
            6: begin
                start_pkt($urandom_range(1, 12));
                raise(2'd3, SE1);
                recover();
            end
            7: begin
                int n;
                start_pkt($urandom_range(1, 12));
                n = $urandom_range(1, 3);
                for (int i = 0; i < n; i++) push(SE0, 0, 0, 0, 0, 1);
                if ($urandom_range(0, 1) != 0) raise(2'd2, K);
                else                           raise(2'd3, SE1);
                recover();
            end
            default: begin
                push(SE0, 0, 0, 0, 0, 0);
                push(SE1, 0, 0, 0, 0, 0);
                idle(1);
            end
        endcase
        idle($urandom_range(0, 2));
    endtask

    initial begin
        vectors = 0;
        errs    = 0;
        level   = J;
        ones    = 0;
        code    = 2'd0;
        line_in = J;
        rst_L   = 1'b1;
        #1 rst_L = 1'b0;
        #3 check_zero("reset");
        repeat (2) @(negedge clk);
        rst_L = 1'b1;

        // Basic packet: J,K,J,K,K,K,SE0,SE0,J -> bits 0,0,0,1,1 then rx_done.
        idle(2);
        send_bit(0); send_bit(0); send_bit(0); send_bit(1); send_bit(1);
        eop(2);
        // Stuffing: 0 + six 1s, stuffed 0 dropped, then a 1.
        idle(1);
        start_pkt(1);
        for (int i = 0; i < 6; i++) send_bit(1'b1);
        send_bit(1'b1);
        eop(2);
        // Stuff violation, then SE0,SE0,J recovery without rx_done.
        idle(1);
        start_pkt(1);
        for (int i = 0; i < 6; i++) send_bit(1'b1);
        raise(2'd1, level);
        push(SE0, 0, 0, 0, 0, 1);
        push(SE0, 0, 0, 0, 0, 1);
        push(J, 0, 0, 0, 0, 0);
        level = J;
        // Stuff pending exactly at EOP is legal.
        idle(1);
        start_pkt(1);
        for (int i = 0; i < 6; i++) send_bit(1'b1);
        eop(3);
        // Bad EOPs and SE1.
        scenario(4);
        scenario(5);
        scenario(6);
        scenario(8);
        run();

        // Reset after 4 symbols of a packet, then a fresh packet.
        start_pkt(1);
        send_bit(1); send_bit(0); send_bit(0);
        run();
        do_reset("rst_mid");
        start_pkt(5);
        eop(2);
        // Reset while recovering from an error clears a held err_code.
        start_pkt(1);
        raise(2'd3, SE1);
        push(K, 0, 0, 0, 0, 1);
        run();
        do_reset("rst_err");
        idle(1);

        for (int n = 0; n < 300; n++) begin
            scenario($urandom_range(0, 8));
            run();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/nrzi_decoder.md
Name: nrzi_decoder

Overview:
- Receive-side counterpart of the transmit NRZI encoder.
- Samples the line one symbol per clk and decodes NRZI to raw bits.
- Removes stuffed bits and detects the EOP (SE0, SE0, J).
- Flags line errors.
- Feeds the receive packet layer (sync/PID/CRC checking downstream).

Parameters:
- STUFF_LEN, 6, number of consecutive decoded 1s after which the next decoded bit is a stuffed 0 and is dropped.
- MAX_SE0, 3, maximum SE0 symbols tolerated in an EOP before declaring an error.

Ports:
- clk  input  1  system clock, one line symbol per rising edge.
- rst_L  input  1  asynchronous active-low reset.
- line_in  input  2  line symbol: J=2'b10, K=2'b01, SE0=2'b00, 2'b11=SE1 (illegal).
- bit_out  output  1  decoded, unstuffed data bit.
- bit_valid  output  1  bit_out is valid this cycle.
- rx_active  output  1  high from packet start until EOP or error recovery completes.
- rx_done  output  1  one-cycle pulse on a clean EOP.
- rx_error  output  1  one-cycle pulse when an error is detected.
- err_code  output  2  0 none, 1 stuff error, 2 bad EOP, 3 SE1; holds until the next packet start.

Behaviour:
- Reset is asynchronous and active-low; one clock domain.
- Reset values: state=IDLE, prev_sym=J, ones_cnt=0, se0_cnt=0, bit_out=0, bit_valid=0, rx_active=0, rx_done=0, rx_error=0, err_code=0.
- Reset mid-packet abandons the packet immediately; no rx_done or rx_error is produced.
- All outputs are registered. The response to the symbol sampled at edge n appears after edge n (1-cycle latency).
- Decode rule: J or K equal to prev_sym gives 1; a J/K transition gives 0. prev_sym updates on every J/K symbol only, never on SE0 or SE1.
- IDLE:
  - line J: stay; rx_active=0.
  - line K: go to RECV; emit bit 0 (J->K); ones_cnt=0; clear err_code; rx_active=1.
  - SE0 or SE1: ignored; no outputs.
- RECV, J/K symbol: decode it.
  - If ones_cnt==STUFF_LEN and the bit is 0: drop it (bit_valid=0), ones_cnt=0.
  - If ones_cnt==STUFF_LEN and the bit is 1: rx_error pulse, err_code=1, go to ERR.
  - Otherwise emit the bit with bit_valid=1. ones_cnt increments on 1 and clears on 0.
  - ones_cnt saturates at STUFF_LEN.
- RECV, SE0: go to EOP with se0_cnt=1; no bit emitted.
- RECV, SE1: rx_error, err_code=3, go to ERR.
- EOP:
  - SE0: se0_cnt++. If se0_cnt would exceed MAX_SE0: rx_error, err_code=2, go to ERR.
  - J with se0_cnt>=2: rx_done pulse, rx_active=0, prev_sym=J, go to IDLE.
  - J with se0_cnt==1, or K, or SE1: rx_error, err_code=2 (3 for SE1), go to ERR.
- ERR:
  - No bit_valid; rx_active stays 1.
  - Waits for any SE0 followed by J, then returns to IDLE with rx_active=0 and prev_sym=J. No rx_done.
- Simultaneous events:
  - A stuff violation on the last data bit before SE0 is reported as a stuff error, because the bit is evaluated before the SE0.
  - rx_done and rx_error are never both high.
- Pending stuff bit at EOP: ones_cnt==STUFF_LEN when SE0 arrives is legal; the counter is discarded.

Test Plan:
- Reset mid-packet: after 4 symbols of a packet, pulse rst_L low -> all outputs zero immediately; next K starts a fresh packet with err_code=0.
- Basic packet: line J,K,J,K,K,K,SE0,SE0,J -> bits 0,0,0,1,1 with bit_valid on 5 consecutive cycles; rx_done pulses 1 cycle after the J sample; rx_active falls the same cycle; err_code=0.
- Stuffing: K followed by 6 K (bits 0,1,1,1,1,1,1), then J (stuffed 0), then J (1) -> 7 valid bits (0 + six 1s); one cycle with bit_valid=0; then bit 1; no error.
- Stuff violation: K then 7 further K (seventh consecutive 1) -> rx_error pulse, err_code=1, no further bit_valid; line SE0,SE0,J returns to IDLE without rx_done.
- Bad EOP: data then SE0,J -> rx_error, err_code=2. Separately, SE0 for 4 symbols -> rx_error, err_code=2 on the fourth.
- SE1 mid-packet: 2'b11 during RECV -> rx_error, err_code=3. Separately, SE0 or SE1 in IDLE -> no outputs change.
